regfile_shadow: RTL and testbench

- Parametrised successor of the CPU register file: two combinational read ports, one synchronous write port, and a hard-wired zero register at address 0.
- Adds a shadow bank for interrupt/context save. A SAVE sequence copies the main bank into the shadow bank; a RESTORE sequence copies it back.
- Copies run one register per cycle, because the shadow bank is single-ported.
- Sits in the datapath in place of the old register file. Control asserts save/restore requests and stalls the core while busy is high.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_shadow_regbank.sv | 45 ++++
 rtl/regfile_shadow.sv | 135 +++++++++++++
 tb/tb_regfile_shadow.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file with shadow bank.
// FSM state encoding and default geometry.
package regfile_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int AW_DEF    = 4;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_SAVE    = 2'b01;
  localparam logic [1:0] ST_RESTORE = 2'b10;

endpackage

// File: rtl/regfile_shadow_regbank.sv
// NREGS x WIDTH register array: one synchronous write port,
// asynchronous clear, NRD combinational read ports.
module regbank
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int NRD   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [AW-1:0]              wa,
  input  logic [WIDTH-1:0]           wd,
  input  logic [NRD-1:0][AW-1:0]     ra,
  output logic [NRD-1:0][WIDTH-1:0]  rd
);

  localparam int NREGS = 2 ** AW;

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rd[g] = mem_q[ra[g]];
  end

endmodule

// File: rtl/regfile_shadow.sv
// Register file with shadow bank for context save/restore.
// Optional REGFILE_BYPASS_EN: same-cycle write-through forwarding to reads.
module regfile_shadow
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             save_req,
  input  logic             restore_req,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy,
  output logic             done,
  output logic             wr_drop
);

  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam logic [AW-1:0] CNT_LAST = '1;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_drop_q, wr_drop_d;

  logic             m_we;
  logic [AW-1:0]    m_wa;
  logic [WIDTH-1:0] m_wd;
  logic             s_we;

  logic [2:0][AW-1:0]    m_ra;
  logic [2:0][WIDTH-1:0] m_rd;
  logic [0:0][AW-1:0]    s_ra;
  logic [0:0][WIDTH-1:0] s_rd;

  logic byp1, byp2;
  logic last;

  assign busy = (state_q != ST_IDLE);
  assign last = (cnt_q == CNT_LAST);
  assign done = busy && last;
  assign wr_drop = wr_drop_q;

  assign m_ra = {cnt_q, ra2, ra1};
  assign s_ra = cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_we      = 1'b0;
    m_wa      = wa3;
    m_wd      = wd3;
    s_we      = 1'b0;
    wr_drop_d = we3 && busy;
    unique case (state_q)
      ST_IDLE: begin
        m_we = we3 && (wa3 != '0);
        if (save_req) begin
          state_d = ST_SAVE;
          cnt_d   = CNT_ONE;
        end else if (restore_req) begin
          state_d = ST_RESTORE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_SAVE: begin
        s_we  = 1'b1;
        cnt_d = cnt_q + CNT_ONE;
        if (last) state_d = ST_IDLE;
      end
      ST_RESTORE: begin
        m_we  = 1'b1;
        m_wa  = cnt_q;
        m_wd  = s_rd[0];
        cnt_d = cnt_q + CNT_ONE;
        if (last) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  regbank #(.WIDTH(WIDTH), .AW(AW), .NRD(3)) u_main (
    .clk   (clk),
    .reset (reset),
    .we    (m_we),
    .wa    (m_wa),
    .wd    (m_wd),
    .ra    (m_ra),
    .rd    (m_rd)
  );

  // Shadow is only ever addressed by the copy counter.
  regbank #(.WIDTH(WIDTH), .AW(AW), .NRD(1)) u_shadow (
    .clk   (clk),
    .reset (reset),
    .we    (s_we),
    .wa    (cnt_q),
    .wd    (m_rd[2]),
    .ra    (s_ra),
    .rd    (s_rd)
  );

`ifdef REGFILE_BYPASS_EN
  assign byp1 = we3 && !busy && (wa3 != '0) && (ra1 == wa3);
  assign byp2 = we3 && !busy && (wa3 != '0) && (ra2 == wa3);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rd1 = byp1 ? wd3 : ((ra1 == '0) ? '0 : m_rd[0]);
  assign rd2 = byp2 ? wd3 : ((ra2 == '0) ? '0 : m_rd[1]);

endmodule

// File: tb/tb_regfile_shadow.sv
// Randomized + directed bench for regfile_shadow against a
// behavioural bank/sequence model.
module tb_regfile_shadow;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we3 = 1'b0;
  logic [3:0]  ra1 = '0, ra2 = '0, wa3 = '0;
  logic [15:0] wd3 = '0;
  logic        save_req = 1'b0, restore_req = 1'b0;
  logic [15:0] rd1, rd2;
  logic        busy, done, wr_drop;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mm [16];
  logic [15:0] sm [16];
  int          copy_left;
  bit          copy_is_save;
  logic        drop_m;

  regfile_shadow dut (
    .clk         (clk),
    .reset       (reset),
    .we3         (we3),
    .ra1         (ra1),
    .ra2         (ra2),
    .wa3         (wa3),
    .wd3         (wd3),
    .save_req    (save_req),
    .restore_req (restore_req),
    .rd1         (rd1),
    .rd2         (rd2),
    .busy        (busy),
    .done        (done),
    .wr_drop     (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mm[i] = '0;
      sm[i] = '0;
    end
    copy_left = 0;
    drop_m = 1'b0;
  endtask

  function automatic logic [15:0] exp_rd(input logic [3:0] ra);
    if (ra == 0) return 16'h0;
    if (BYP && we3 && copy_left == 0 && wa3 == ra) return wd3;
    return mm[ra];
  endfunction

  task automatic idle_in();
    we3 = 1'b0;
    save_req = 1'b0;
    restore_req = 1'b0;
  endtask

  // One clock: check combinational outputs, advance model, check wr_drop.
  task automatic cyc();
    int reg_no;
    #1;
    check("rd1", rd1, exp_rd(ra1));
    check("rd2", rd2, exp_rd(ra2));
    check("busy", busy, copy_left != 0);
    check("done", done, copy_left == 1);
    drop_m = we3 && copy_left != 0;
    if (copy_left == 0) begin
      if (we3 && wa3 != 0) mm[wa3] = wd3;
      if (save_req || restore_req) begin
        copy_left = 15;
        copy_is_save = save_req;
      end
    end else begin
      reg_no = 16 - copy_left;
      if (copy_is_save) sm[reg_no] = mm[reg_no];
      else mm[reg_no] = sm[reg_no];
      copy_left--;
    end
    @(posedge clk);
    #1;
    check("wr_drop", wr_drop, drop_m);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    idle_in();
    we3 = 1'b1;
    wa3 = a;
    wd3 = d;
    cyc();
    idle_in();
  endtask

  task automatic run_copy(input bit inject);
    int nb = 0;
    int nd = 0;
    int k = 0;
    while (busy && k < 40) begin
      idle_in();
      ra1 = 4'($urandom);
      ra2 = 4'($urandom);
      if (inject && nb == 5) begin
        we3 = 1'b1;
        wa3 = 4'd7;
        wd3 = 16'hAAAA;
      end
      if (inject && nb == 8) restore_req = 1'b1;
      nb++;
      if (done) nd++;
      cyc();
      k++;
    end
    idle_in();
    if (k == 40) check("copy_timeout", 1, 0);
    check("busy_len", nb, 15);
    check("done_cnt", nd, 1);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      idle_in();
      ra1 = 4'(i);
      ra2 = 4'(15 - i);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ra1 = 4'd5;
    ra2 = 4'd0;
    cyc();

    wr(4'd3, 16'hBEEF);
    ra1 = 4'd3;
    cyc();
    check("r3_beef", rd1, 16'hBEEF);
    ra1 = 4'd0;
    wr(4'd0, 16'h1234);
    cyc();

    for (int i = 1; i < 16; i++) wr(4'(i), 16'(i * 16'h11));
    save_req = 1'b1;
    cyc();
    idle_in();
    run_copy(1'b1);
    read_all();
    for (int i = 1; i < 16; i++) wr(4'(i), 16'hFFFF);
    restore_req = 1'b1;
    cyc();
    idle_in();
    run_copy(1'b0);
    ra1 = 4'd7;
    ra2 = 4'd15;
    cyc();
    check("r7_restored", rd1, 16'h0077);
    check("r15_restored", rd2, 16'h00FF);
    read_all();

    wr(4'd2, 16'h1234);
    save_req = 1'b1;
    restore_req = 1'b1;
    cyc();
    idle_in();
    run_copy(1'b0);
    wr(4'd2, 16'h0000);
    restore_req = 1'b1;
    cyc();
    idle_in();
    run_copy(1'b0);
    ra1 = 4'd2;
    cyc();
    check("r2_both_req", rd1, 16'h1234);

    for (int n = 0; n < 400; n++) begin
      we3 = 1'($urandom);
      wa3 = 4'($urandom);
      wd3 = 16'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom);
      ra2 = 4'($urandom);
      save_req = ($urandom_range(0, 29) == 0);
      restore_req = ($urandom_range(0, 29) == 0);
      cyc();
    end
    idle_in();
    for (int k = 0; k < 20 && busy; k++) cyc();
    read_all();

    save_req = 1'b1;
    cyc();
    idle_in();
    repeat (6) cyc();
    reset = 1'b1;
    #1;
    model_clear();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", wr_drop, 0);
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i);
      #1;
      check("rst_rd", rd1, 16'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    save_req = 1'b1;
    cyc();
    idle_in();
    check("resave_busy", busy, 1);
    run_copy(1'b0);

    if (BYP) begin
      idle_in();
      we3 = 1'b1;
      wa3 = 4'd4;
      ra1 = 4'd4;
      wd3 = 16'h5A5A;
      #1;
      check("bypass_rd1", rd1, 16'h5A5A);
      cyc();
      idle_in();
    end
    wr(4'd4, 16'h5A5A);
    ra1 = 4'd4;
    cyc();
    check("r4_after", rd1, 16'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
